if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the pipelined RISC-V core. It sits directly upstream of the decode/controller logic and feeds it.
- Holds the program counter and drives the instruction-memory address.
- Captures the returned word together with its PC into the IF/ID register.
- Honours stall requests from the hazard unit and redirects from EX (taken branch/jump, which flushes the wrong-path instruction).

---
 rtl/if_stage_if.sv | 12 +
 rtl/if_stage.sv | 72 +++++++
 tb/tb_if_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a
// combinational-read instruction memory (slave).
interface if_stage_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register, with hazard stall and EX redirect/flush.
module if_stage #(
    parameter int              DATA_W    = 32,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    if_stage_if.master        imem,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [PC_W-1:0]   id_pc4,
    output logic [DATA_W-1:0] id_instr,
    output logic [31:0]       fetch_cnt,
    output logic              misalign_err
);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR);

    logic [PC_W-1:0]   pc_reg;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   redirect_target;
    logic              id_valid_reg;
    logic [PC_W-1:0]   id_pc_reg;
    logic [PC_W-1:0]   id_pc4_reg;
    logic [DATA_W-1:0] id_instr_reg;
    logic [31:0]       fetch_cnt_reg;
    logic              misalign_reg;

    // Sequential PC arithmetic wraps naturally at 2^PC_W.
    assign pc_plus4        = pc_reg + PC_W'(4);
    assign redirect_target = {redirect_pc[PC_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= RESET_PC;
            id_valid_reg  <= 1'b0;
            id_pc_reg     <= '0;
            id_pc4_reg    <= '0;
            id_instr_reg  <= NOP_WORD;
            fetch_cnt_reg <= '0;
            misalign_reg  <= 1'b0;
        end else if (redirect_valid) begin
            // Flush the wrong-path instruction; id_pc/id_pc4 keep their values.
            pc_reg       <= redirect_target;
            id_valid_reg <= 1'b0;
            id_instr_reg <= NOP_WORD;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_reg <= 1'b1;
            end
        end else if (!stall) begin
            pc_reg        <= pc_plus4;
            id_valid_reg  <= 1'b1;
            id_pc_reg     <= pc_reg;
            id_pc4_reg    <= pc_plus4;
            id_instr_reg  <= imem.imem_rdata;
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign imem.imem_addr = pc_reg;
    assign id_valid       = id_valid_reg;
    assign id_pc          = id_pc_reg;
    assign id_pc4         = id_pc4_reg;
    assign id_instr       = id_instr_reg;
    assign fetch_cnt      = fetch_cnt_reg;
    assign misalign_err   = misalign_reg;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each driven cycle pushes the expected
// post-edge state, which the scenario task pops and compares after the edge.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [31:0] fetch_cnt;
    logic        misalign_err;

    if_stage_if #(.PC_W(32), .DATA_W(32)) bus ();

    if_stage #(
        .DATA_W(32), .PC_W(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .id_instr       (id_instr),
        .fetch_cnt      (fetch_cnt),
        .misalign_err   (misalign_err)
    );

    // Memory word k (byte address 4k) holds 0x1000_0000 + k.
    assign bus.imem_rdata = 32'h1000_0000 + (bus.imem_addr >> 2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        mis;
    } state_t;

    state_t sb[$];
    state_t e;
    state_t o;
    int     n_checks = 0;
    int     n_errors = 0;
    int     txn      = 0;

    // Reference model state
    logic [31:0] m_pc, m_idpc, m_idpc4, m_instr, m_cnt;
    logic        m_valid, m_mis;

    function automatic state_t observe();
        state_t s;
        s.addr = bus.imem_addr; s.valid = id_valid; s.pc = id_pc; s.pc4 = id_pc4;
        s.instr = id_instr; s.cnt = fetch_cnt; s.mis = misalign_err;
        return s;
    endfunction

    function automatic string fmt(state_t s);
        return $sformatf("addr=%h v=%b pc=%h pc4=%h instr=%h cnt=%0d mis=%b",
                         s.addr, s.valid, s.pc, s.pc4, s.instr, s.cnt, s.mis);
    endfunction

    task automatic drive(input logic rst, input logic stl, input logic rdv,
                         input logic [31:0] rpc);
        state_t x;
        reset = rst; stall = stl; redirect_valid = rdv; redirect_pc = rpc;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_idpc = '0; m_idpc4 = '0;
            m_instr = NOP; m_cnt = '0; m_mis = 1'b0;
        end else if (rdv) begin
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
            m_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_instr = NOP;
        end else if (!stl) begin
            m_valid = 1'b1; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
            m_instr = 32'h1000_0000 + (m_pc >> 2);
            m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
        end
        x.addr = m_pc; x.valid = m_valid; x.pc = m_idpc; x.pc4 = m_idpc4;
        x.instr = m_instr; x.cnt = m_cnt; x.mis = m_mis;
        sb.push_back(x);
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: rst=%b stall=%b redir=%b rpc=%h -> %s",
                 txn, rst, stl, rdv, rpc, fmt(observe()));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reset: got %s need %s", fmt(o), fmt(e));
            end
        end
        n_checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || bus.imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_values: got v=%b instr=%h addr=%h need v=0 instr=%h addr=0",
                     id_valid, id_instr, bus.imem_addr, NOP);
        end
    endtask

    task automatic test_straight();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL straight: got %s need %s", fmt(o), fmt(e));
            end
        end
        n_checks++;
        if (id_pc !== 32'd8 || id_pc4 !== 32'd12 || id_instr !== 32'h1000_0002 || fetch_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL straight_end: got pc=%h pc4=%h instr=%h cnt=%0d need 8/c/10000002/3",
                     id_pc, id_pc4, id_instr, fetch_cnt);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL stall: got %s need %s", fmt(o), fmt(e));
            end
        end
        n_checks++;
        if (bus.imem_addr !== 32'd12 || id_pc !== 32'd8 || id_valid !== 1'b1 || fetch_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_hold: got addr=%h pc=%h v=%b cnt=%0d need c/8/1/3",
                     bus.imem_addr, id_pc, id_valid, fetch_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || id_pc !== 32'd12) begin
            n_errors++;
            $display("FAIL stall_resume: got %s need %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 1'b1, 32'h40);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || bus.imem_addr !== 32'h40 || id_valid !== 1'b0 || id_instr !== NOP) begin
            n_errors++;
            $display("FAIL redirect_flush: got %s need %s", fmt(o), fmt(e));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || id_pc !== 32'h40 || id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL redirect_fetch: got %s need %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt [3] = '{32'h80, 32'h90, 32'h0};
        logic        rd  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, rd[i], tgt[i]);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL back_to_back: got %s need %s", fmt(o), fmt(e));
            end
        end
        n_checks++;
        if (id_pc !== 32'h90 || id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL back_to_back_end: got pc=%h v=%b need 90/1", id_pc, id_valid);
        end
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b0, 1'b1, 32'h46);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || bus.imem_addr !== 32'h44 || misalign_err !== 1'b1) begin
            n_errors++;
            $display("FAIL misalign: got %s need %s", fmt(o), fmt(e));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h50);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
        end
        o = observe(); n_checks++;
        if (o !== e || misalign_err !== 1'b1) begin
            n_errors++;
            $display("FAIL misalign_sticky: got %s need %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        e = sb.pop_front();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || bus.imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap: got %s need %s", fmt(o), fmt(e));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || id_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_next: got %s need %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b1, 32'h46);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e || bus.imem_addr !== 32'h0 || id_valid !== 1'b0 || fetch_cnt !== 32'h0
            || misalign_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got %s need %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_random();
        logic        s, r;
        logic [31:0] t;
        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = $urandom & 32'h0000_0FFF;
            drive(1'b0, s, r, t);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL random: got %s need %s", fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        m_pc = '0; m_idpc = '0; m_idpc4 = '0; m_instr = NOP; m_cnt = '0;
        m_valid = 1'b0; m_mis = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
